// File: rtl/divider_toplevel_seq.sv
// ---------------------------------------------------------------------------
// divider_toplevel_seq
//   Sequential restoring divider, the inverse datapath of the shift-add
//   multiplier. Operands are captured on Start in IDLE. One quotient bit is
//   produced per clock. Quotient/Remainder are registered and hold their
//   value until the next operation finishes.
//
// Ports
//   Clk        in   1      system clock, rising edge
//   Reset      in   1      asynchronous, active-low reset
//   Start      in   1      run request (level), must drop between operations
//   Dividend   in   WIDTH  numerator, captured in IDLE when Start=1
//   Divisor    in   WIDTH  denominator, captured with Dividend
//   Quotient   out  WIDTH  registered quotient
//   Remainder  out  WIDTH  registered remainder
//   Busy       out  1      high in LOAD/CALC/FIX
//   Done       out  1      high in DONE only
//   DivZero    out  1      last operation had Divisor==0
//
// Configuration
//   DIVIDER_SIGNED_EN : when defined, operands are two's complement and the
//   result truncates toward zero (remainder takes the dividend's sign).
//   When undefined, operands are unsigned.
// ---------------------------------------------------------------------------
module divider_toplevel_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_dividendMag;
  logic [WIDTH-1:0] w_divisorMag;
  logic [WIDTH-1:0] w_quoFix;
  logic [WIDTH-1:0] w_remFix;
  logic [WIDTH+1:0] w_shRem;
  logic [WIDTH:0]   w_diff;
  logic             w_geq;
  logic             w_lastIter;

`ifdef DIVIDER_SIGNED_EN
  // Magnitudes wrap for the most-negative value, which is exactly what the
  // unsigned core needs (0x80 stays 0x80 as an unsigned magnitude).
  assign w_dividendMag = r_dividend[WIDTH-1] ? -r_dividend : r_dividend;
  assign w_divisorMag  = r_divisor[WIDTH-1]  ? -r_divisor  : r_divisor;
  assign w_quoFix = (r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1]) ? -r_quo : r_quo;
  assign w_remFix = r_dividend[WIDTH-1] ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`else
  assign w_dividendMag = r_dividend;
  assign w_divisorMag  = r_divisor;
  assign w_quoFix      = r_quo;
  assign w_remFix      = r_rem[WIDTH-1:0];
`endif

  // Shifted partial remainder, with one extra headroom bit so the compare
  // sees the full value. After a restore R < D, so the shifted value always
  // fits in WIDTH+1 bits and the difference needs no extra sign bit.
  assign w_shRem    = {r_rem, r_quo[WIDTH-1]};
  assign w_geq      = (w_shRem >= {2'b00, r_den});
  assign w_diff     = w_shRem[WIDTH:0] - {1'b0, r_den};
  assign w_lastIter = (r_count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status decode. A zero divisor still passes through FIX
  // so that the divide-by-zero result appears one cycle after LOAD.
  always_comb begin
    w_stateNext = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) w_stateNext = S_LOAD;
      end
      S_LOAD: begin
        Busy        = 1'b1;
        w_stateNext = (r_divisor == '0) ? S_FIX : S_CALC;
      end
      S_CALC: begin
        Busy = 1'b1;
        if (w_lastIter) w_stateNext = S_FIX;
      end
      S_FIX: begin
        Busy        = 1'b1;
        w_stateNext = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (!Start) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations, and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_den      <= '0;
      r_count    <= '0;
      Quotient   <= '0;
      Remainder  <= '0;
      DivZero    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_dividend <= Dividend;
            r_divisor  <= Divisor;
          end
        end
        S_LOAD: begin
          r_rem   <= '0;
          r_quo   <= w_dividendMag;
          r_den   <= w_divisorMag;
          r_count <= '0;
          if (r_divisor == '0) begin
            Quotient  <= '1;
            Remainder <= r_dividend;
            DivZero   <= 1'b1;
          end else begin
            DivZero <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem   <= w_geq ? w_diff : w_shRem[WIDTH:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_geq};
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (!DivZero) begin
            Quotient  <= w_quoFix;
            Remainder <= w_remFix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_toplevel_seq.sv
// ---------------------------------------------------------------------------
// tb_divider_toplevel_seq
//   Table-driven bench for divider_toplevel_seq (WIDTH=8). Expected results
//   are pushed to a scoreboard queue when an operation starts and popped when
//   Done is seen. Hand-written sequences cover held Start, operand changes in
//   DONE and an asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_divider_toplevel_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Dividend = '0;
  logic [7:0] Divisor = '0;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  divider_toplevel_seq #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic [7:0] a, logic [7:0] b, logic [7:0] q,
                                 logic [7:0] r, logic dz, int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (called at a negedge after edge 1) until Done, returning the
  // number of the edge after which Done was first seen, or -1 on timeout.
  task automatic waitDone(output int lat);
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    if (Done !== 1'b1) lat = -1;
  endtask

  task automatic popAndCompare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_quotient"}, 32'(Quotient), 32'(e.q));
    checkOutput({tag, "_remainder"}, 32'(Remainder), 32'(e.r));
    checkOutput({tag, "_divZero"}, 32'(DivZero), 32'(e.dz));
    checkOutput({tag, "_busyDone"}, 32'(Busy), 32'd0);
  endtask

  // Single operation with a one-cycle Start pulse.
  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    int lat;
    @(negedge Clk);
    Dividend = v.a;
    Divisor  = v.b;
    Start    = 1'b1;
    e.q = v.q; e.r = v.r; e.dz = v.dz;
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    checkOutput({tag, "_busyLoad"}, 32'(Busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.lat));
    if (lat < 0) begin
      void'(sb.pop_front());
    end else begin
      popAndCompare(tag);
    end
    @(posedge Clk);
    @(negedge Clk);
    checkOutput({tag, "_doneFalls"}, 32'(Done), 32'd0);
    checkOutput({tag, "_qHoldIdle"}, 32'(Quotient), 32'(v.q));
  endtask

  initial begin
    int lat;
    int doneDrops;
    int busySeen;
    exp_t e;

    vecs.push_back(mkVec(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 11));
    vecs.push_back(mkVec(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 11));
    vecs.push_back(mkVec(8'h03, 8'h0A, 8'h00, 8'h03, 1'b0, 11));
    vecs.push_back(mkVec(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 3));
    vecs.push_back(mkVec(8'h2A, 8'h2A, 8'h01, 8'h00, 1'b0, 11));
    vecs.push_back(mkVec(8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 11));
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back(mkVec(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 11));
    vecs.push_back(mkVec(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 11));
    vecs.push_back(mkVec(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 11));
    vecs.push_back(mkVec(8'hFF, 8'h10, 8'h00, 8'hFF, 1'b0, 11));
    vecs.push_back(mkVec(8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0, 11));
`else
    vecs.push_back(mkVec(8'h9C, 8'h07, 8'h16, 8'h02, 1'b0, 11));
    vecs.push_back(mkVec(8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 11));
    vecs.push_back(mkVec(8'h80, 8'h03, 8'h2A, 8'h02, 1'b0, 11));
    vecs.push_back(mkVec(8'hFE, 8'hFF, 8'h00, 8'hFE, 1'b0, 11));
`endif
    vecs.push_back(mkVec(8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 3));

    // Reset state.
    repeat (2) @(negedge Clk);
    checkOutput("rst_quotient", 32'(Quotient), 32'd0);
    checkOutput("rst_remainder", 32'(Remainder), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_done", 32'(Done), 32'd0);
    checkOutput("rst_divZero", 32'(DivZero), 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Start held through DONE: one operation only, operands ignored in DONE.
    @(negedge Clk);
    Dividend = 8'h64;
    Divisor  = 8'h07;
    Start    = 1'b1;
    e.q = 8'h0E; e.r = 8'h02; e.dz = 1'b0;
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    waitDone(lat);
    checkOutput("held_latency", 32'(lat), 32'd11);
    if (lat < 0) void'(sb.pop_front());
    else popAndCompare("held");
    doneDrops = 0;
    busySeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (c == 5) begin
        Dividend = 8'h03;
        Divisor  = 8'h0A;
      end
      if (Done !== 1'b1) doneDrops++;
      if (Busy !== 1'b0) busySeen++;
    end
    checkOutput("held_doneDrops", 32'(doneDrops), 32'd0);
    checkOutput("held_busySeen", 32'(busySeen), 32'd0);
    checkOutput("held_quotient", 32'(Quotient), 32'h0E);
    checkOutput("held_remainder", 32'(Remainder), 32'h02);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("held_idleDone", 32'(Done), 32'd0);
    checkOutput("held_idleBusy", 32'(Busy), 32'd0);
    checkOutput("held_idleQuotient", 32'(Quotient), 32'h0E);

    // Asynchronous reset during edge 6 of a 0x64/0x07 run.
    @(negedge Clk);
    Dividend = 8'h64;
    Divisor  = 8'h07;
    Start    = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    checkOutput("arst_busyBefore", 32'(Busy), 32'd1);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("arst_quotient", 32'(Quotient), 32'd0);
    checkOutput("arst_remainder", 32'(Remainder), 32'd0);
    checkOutput("arst_busy", 32'(Busy), 32'd0);
    checkOutput("arst_done", 32'(Done), 32'd0);
    checkOutput("arst_divZero", 32'(DivZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(mkVec(8'h10, 8'h04, 8'h04, 8'h00, 1'b0, 11), "postReset");

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
